debug_uart_rx: RTL

Serial receiver feeding the debug unit of the MIPS pipeline: deserializes 8N1 UART frames from the host PC line and presents each byte on a one-deep holding register with a valid/ack handshake. The debug unit pops bytes as command/control input (e.g. the request to read registers). It contains its own 16x-oversampling baud-tick generator, an input synchronizer, and sticky framing/overrun flags.

---
 rtl/debug_uart_rx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/debug_uart_rx.sv
// 8N1 UART receiver for the debug unit: 16x oversampling, one-deep holding register
// with valid/ack handshake, sticky framing and overrun flags.
module debug_uart_rx #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 19200,
  parameter int TICK_DIV = CLK_HZ / (BAUD * 16)
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       rx,
  input  logic       rx_ack,
  input  logic       clear_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       framing_err,
  output logic       overrun
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (TICK_DIV < 2) begin : g_bad_div
    $error("debug_uart_rx: TICK_DIV must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rxs_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          framing_err_q, framing_err_d;
  logic          overrun_q, overrun_d;
  logic          tick;
  logic          frame_ok;
  logic          frame_bad;
  logic          load;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    shift_d   = shift_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          s_d     = 4'd0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == 4'd7) begin
            if (!rxs_q) begin
              state_d = DATA;
              s_d     = 4'd0;
              n_d     = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            shift_d = {rxs_q, shift_q[7:1]};
            s_d     = 4'd0;
            if (n_q == 3'd7) state_d = STOP;
            else             n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            if (rxs_q) begin
              frame_ok = 1'b1;
              state_d  = IDLE;
            end else begin
              frame_bad = 1'b1;
              state_d   = BREAK;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      BREAK: begin
        // a held-low line must return high before another start bit counts
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    load       = frame_ok && (!rx_valid_q || rx_ack);
    if (load) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
    // a setting event in the same cycle as clear_err leaves the flag set
    overrun_d     = (overrun_q & ~clear_err) | (frame_ok & rx_valid_q & ~rx_ack);
    framing_err_d = (framing_err_q & ~clear_err) | frame_bad;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      tick_cnt_q    <= '0;
      state_q       <= IDLE;
      s_q           <= 4'd0;
      n_q           <= 3'd0;
      shift_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rxs_q         <= rx_meta_q;
      tick_cnt_q    <= tick_cnt_d;
      state_q       <= state_d;
      s_q           <= s_d;
      n_q           <= n_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule
